// File: rtl/i2c_clk_gen.sv
// i2c_clk_gen: quarter-period phase generator providing SCL/SDA timing clocks and phase strobes
// for the DDC I2C master. Define I2C_CLK_STRETCH_EN to add slave clock-stretch support via scl_in.
module i2c_clk_gen #(
  parameter int unsigned QUARTER_CYCLES = 63
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
`ifdef I2C_CLK_STRETCH_EN
  input  logic scl_in,
`endif
  output logic i2c_clk_div,
  output logic i2c_sda_clk_div,
  output logic scl_fall_stb,
  output logic sda_change_stb,
  output logic scl_rise_stb,
  output logic sda_sample_stb
);

  localparam int unsigned QW = 16;
  localparam logic [QW-1:0] QMAX = 16'(QUARTER_CYCLES - 1);

  localparam logic [1:0] PH_LOW    = 2'd0;
  localparam logic [1:0] PH_CHANGE = 2'd1;
  localparam logic [1:0] PH_HIGH   = 2'd2;
  localparam logic [1:0] PH_SAMPLE = 2'd3;

  logic [QW-1:0] qcnt, qcnt_nxt;
  logic [1:0]    phase, phase_nxt;
  logic [3:0]    stb_nxt;
  logic          scl_nxt, sda_nxt;
  logic          hold_c;

`ifdef I2C_CLK_STRETCH_EN
  logic scl_meta, scl_sync;

  // Bus SCL readback synchronizer; resets to the idle-high bus level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
    end else begin
      scl_meta <= scl_in;
      scl_sync <= scl_meta;
    end
  end

  // A slave holding SCL low during the high phase freezes the count
  assign hold_c = (phase == PH_HIGH) && !scl_sync;
`else
  assign hold_c = 1'b0;
`endif

  // Next-state and next-output decode; outputs follow the next phase so they move with it
  always_comb begin
    qcnt_nxt  = qcnt;
    phase_nxt = phase;
    stb_nxt   = 4'b0000;
    if (!en) begin
      qcnt_nxt  = '0;
      phase_nxt = PH_SAMPLE;
    end else if (hold_c) begin
      qcnt_nxt  = qcnt;
    end else if (qcnt == QMAX) begin
      qcnt_nxt  = '0;
      phase_nxt = phase + 2'd1;
      stb_nxt   = 4'b0001 << phase_nxt;
    end else begin
      qcnt_nxt  = qcnt + 16'd1;
    end
    scl_nxt = (phase_nxt == PH_HIGH) || (phase_nxt == PH_SAMPLE);
    sda_nxt = (phase_nxt == PH_CHANGE) || (phase_nxt == PH_HIGH);
  end

  // State and output registers; reset and disable both land in idle (phase 3, SCL high)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qcnt            <= '0;
      phase           <= PH_SAMPLE;
      i2c_clk_div     <= 1'b1;
      i2c_sda_clk_div <= 1'b0;
      scl_fall_stb    <= 1'b0;
      sda_change_stb  <= 1'b0;
      scl_rise_stb    <= 1'b0;
      sda_sample_stb  <= 1'b0;
    end else begin
      qcnt            <= qcnt_nxt;
      phase           <= phase_nxt;
      i2c_clk_div     <= scl_nxt;
      i2c_sda_clk_div <= sda_nxt;
      scl_fall_stb    <= stb_nxt[PH_LOW];
      sda_change_stb  <= stb_nxt[PH_CHANGE];
      scl_rise_stb    <= stb_nxt[PH_HIGH];
      sda_sample_stb  <= stb_nxt[PH_SAMPLE];
    end
  end

endmodule

// File: tb/tb_i2c_clk_gen.sv
// Self-checking bench for i2c_clk_gen: directed timing scenarios plus randomized en/reset
// traffic compared against an arithmetic phase model (stretch scenario with I2C_CLK_STRETCH_EN).
module tb_i2c_clk_gen;

  localparam int QI = 63;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic i2c_clk_div, i2c_sda_clk_div;
  logic scl_fall_stb, sda_change_stb, scl_rise_stb, sda_sample_stb;
`ifdef I2C_CLK_STRETCH_EN
  logic scl_in = 1'b1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] stb_v;
  logic [5:0] obs;
  assign stb_v = {sda_sample_stb, scl_rise_stb, sda_change_stb, scl_fall_stb};
  assign obs   = {i2c_clk_div, i2c_sda_clk_div, stb_v};

  i2c_clk_gen #(.QUARTER_CYCLES(QI)) dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
`ifdef I2C_CLK_STRETCH_EN
    .scl_in          (scl_in),
`endif
    .i2c_clk_div     (i2c_clk_div),
    .i2c_sda_clk_div (i2c_sda_clk_div),
    .scl_fall_stb    (scl_fall_stb),
    .sda_change_stb  (sda_change_stb),
    .scl_rise_stb    (scl_rise_stb),
    .sda_sample_stb  (sda_sample_stb)
  );

  always #20 clk = ~clk;

  // Reference model: m_n counts quarter-period ticks run since idle; idle sits at tick 3*QI
  int   m_n = 0;
  logic m_stb = 1'b0;
  logic m_stall;

`ifdef I2C_CLK_STRETCH_EN
  logic m_s1 = 1'b1, m_s2 = 1'b1;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 <= 1'b1;
      m_s2 <= 1'b1;
    end else begin
      m_s1 <= scl_in;
      m_s2 <= m_s1;
    end
  end
  assign m_stall = (((3 * QI + m_n) / QI) % 4 == 2) && !m_s2;
`else
  assign m_stall = 1'b0;
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_n   <= 0;
      m_stb <= 1'b0;
    end else if (!en) begin
      m_n   <= 0;
      m_stb <= 1'b0;
    end else if (m_stall) begin
      m_stb <= 1'b0;
    end else begin
      m_n   <= m_n + 1;
      m_stb <= ((m_n + 1) % QI) == 0;
    end
  end

  function automatic logic [5:0] model_vec();
    int p;
    logic [3:0] s;
    p = ((3 * QI + m_n) / QI) % 4;
    s = m_stb ? 4'(1 << p) : 4'b0000;
    return {p >= 2, (p == 1) || (p == 2), s};
  endfunction

  task automatic test_reset();
    en = 1'b1;
    #5 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 6'b10_0000) begin
      n_err++;
      $display("FAIL reset_async: got %b want %b", obs, 6'b10_0000);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== 6'b10_0000) begin
      n_err++;
      $display("FAIL reset_held: got %b want %b", obs, 6'b10_0000);
    end
  endtask

  // Runs 320 edges from idle, checking the model every cycle and the fixed landmark edges
  task automatic run_from_idle(input string tag);
    logic [5:0] exp;
    bit mark;
    for (int k = 1; k <= 320; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== model_vec()) begin
        n_err++;
        $display("FAIL %s_model edge %0d: got %b want %b", tag, k, obs, model_vec());
      end
      mark = 1'b1;
      exp  = 6'b00_0000;
      case (k)
        62:      exp = 6'b10_0000;
        63:      exp = 6'b00_0001;
        126:     exp = 6'b01_0010;
        189:     exp = 6'b11_0100;
        252:     exp = 6'b10_1000;
        315:     exp = 6'b00_0001;
        default: mark = 1'b0;
      endcase
      if (mark) begin
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL %s_edge%0d: got %b want %b", tag, k, obs, exp);
        end
      end
    end
  endtask

  task automatic test_first_run();
    @(negedge clk);
    reset = 1'b0;
    run_from_idle("first_run");
  endtask

  task automatic test_ten_periods();
    int len;
    int cnt[4] = '{default: 0};
    logic prev_scl;
    logic [3:0] prev_stb;
    bit found = 1'b0;
    bit wide = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (scl_fall_stb) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL ten_periods_sync: got no scl_fall_stb want one within 300 cycles");
      return;
    end
    len = 1;
    prev_scl = i2c_clk_div;
    prev_stb = stb_v;
    for (int c = 1; c <= 10 * 4 * QI; c++) begin
      @(negedge clk);
      if (i2c_clk_div !== prev_scl) begin
        n_cmp++;
        if (len != 2 * QI) begin
          n_err++;
          $display("FAIL ten_periods_interval cycle %0d: got %0d want %0d", c, len, 2 * QI);
        end
        len = 1;
        prev_scl = i2c_clk_div;
      end else begin
        len++;
      end
      if ((stb_v & prev_stb) != 4'b0000) wide = 1'b1;
      for (int j = 0; j < 4; j++) if (stb_v[j]) cnt[j]++;
      prev_stb = stb_v;
    end
    n_cmp++;
    if (wide) begin
      n_err++;
      $display("FAIL ten_periods_width: got multi-cycle strobe want single-cycle");
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (cnt[j] != 10) begin
        n_err++;
        $display("FAIL ten_periods_count stb%0d: got %0d want 10", j, cnt[j]);
      end
    end
  endtask

  task automatic test_en_drop();
    bit found = 1'b0;
    int fall_at = -1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (sda_change_stb) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL en_drop_sync: got no sda_change_stb want one within 300 cycles");
      return;
    end
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== 6'b10_0000) begin
      n_err++;
      $display("FAIL en_drop_idle: got %b want %b", obs, 6'b10_0000);
    end
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int k = 1; k <= 100 && fall_at < 0; k++) begin
      @(negedge clk);
      if (i2c_clk_div === 1'b0) begin
        fall_at = k;
        n_cmp++;
        if (scl_fall_stb !== 1'b1) begin
          n_err++;
          $display("FAIL en_drop_fall_stb: got %b want 1", scl_fall_stb);
        end
      end
    end
    n_cmp++;
    if (fall_at != QI) begin
      n_err++;
      $display("FAIL en_drop_restart: got fall at %0d want %0d", fall_at, QI);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (scl_rise_stb) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL reset_mid_sync: got no scl_rise_stb want one within 300 cycles");
      return;
    end
    repeat (10) @(negedge clk);
    #5 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 6'b10_0000) begin
      n_err++;
      $display("FAIL reset_mid_idle: got %b want %b", obs, 6'b10_0000);
    end
    @(negedge clk);
    reset = 1'b0;
    run_from_idle("reset_mid");
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== model_vec()) begin
        n_err++;
        $display("FAIL random_model cycle %0d: got %b want %b", c, obs, model_vec());
      end
      if ($urandom_range(0, 999) == 0) begin
        #5 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 6'b10_0000) begin
          n_err++;
          $display("FAIL random_reset cycle %0d: got %b want %b", c, obs, 6'b10_0000);
        end
        #4 reset = 1'b0;
      end
      if (!en) en = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 399) == 0) en = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
      scl_in = ($urandom_range(0, 3) != 0);
`endif
    end
    en = 1'b1;
`ifdef I2C_CLK_STRETCH_EN
    scl_in = 1'b1;
`endif
  endtask

`ifdef I2C_CLK_STRETCH_EN
  // Slave holds SCL low for 40 cycles from the start of the high phase
  task automatic test_stretch();
    bit found = 1'b0;
    bit fell = 1'b0;
    int hi, rise_n, samp_n;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (scl_rise_stb) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL stretch_sync: got no scl_rise_stb want one within 400 cycles");
      return;
    end
    hi = 1;
    rise_n = 1;
    samp_n = 0;
    scl_in = 1'b0;
    for (int c = 1; c <= 400 && !fell; c++) begin
      @(negedge clk);
      if (c == 40) scl_in = 1'b1;
      n_cmp++;
      if (obs !== model_vec()) begin
        n_err++;
        $display("FAIL stretch_model cycle %0d: got %b want %b", c, obs, model_vec());
      end
      if (i2c_clk_div === 1'b1) hi++;
      else fell = 1'b1;
      if (scl_rise_stb) rise_n++;
      if (sda_sample_stb) samp_n++;
    end
    n_cmp++;
    if (hi != 2 * QI + 40) begin
      n_err++;
      $display("FAIL stretch_high_len: got %0d want %0d", hi, 2 * QI + 40);
    end
    n_cmp++;
    if (rise_n != 1 || samp_n != 1) begin
      n_err++;
      $display("FAIL stretch_strobes: got rise %0d sample %0d want 1 and 1", rise_n, samp_n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_run();
    test_ten_periods();
    test_en_drop();
    test_reset_mid();
    test_random();
`ifdef I2C_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
